// File: rtl/fp_pkg.sv
// fp_pkg: shared types and constants for the FP normalize-and-round stage.
package fp_pkg;
    localparam int MANT_W = 24;
    localparam int EXP_W = 8;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    // Working exponent is one bit wider so overflow past 254 stays visible.
    localparam logic [EXP_W:0] E_TOP = {1'b0, EXP_MAX};
    localparam logic [EXP_W:0] E_ONE = {{EXP_W{1'b0}}, 1'b1};
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    typedef struct packed {
        logic sign;
        logic [EXP_W-1:0] exp;
        logic [MANT_W-2:0] frac;
    } fp32_t;
endpackage

// File: rtl/fp_normalizer_if.sv
// fp_normalizer_if: operand-in / result-out handshake bundle of the normalizer.
interface fp_normalizer_if;
    import fp_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [MANT_W-1:0] aligned_result;
    logic carry_out;
    logic aligned_sign;
    logic [2:0] grs;
    logic [EXP_W-1:0] exponent;
    logic out_valid;
    logic out_ready;
    logic [31:0] result;
    logic overflow;
    modport master (
        output in_valid, aligned_result, carry_out, aligned_sign, grs, exponent, out_ready,
        input in_ready, out_valid, result, overflow
    );
    modport slave (
        input in_valid, aligned_result, carry_out, aligned_sign, grs, exponent, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/fp_round.sv
// fp_round: round-to-nearest-even, renormalize after round, and pack special cases.
module fp_round
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0] i_m,
    input  logic              i_g,
    input  logic              i_r,
    input  logic              i_s,
    input  logic              i_sign,
    input  logic [EXP_W:0]    i_e,
    output fp32_t             o_result,
    output logic              o_overflow
);
    logic              w_up;
    logic              w_zero;
    logic [MANT_W:0]   w_sum;
    logic [MANT_W-1:0] w_m;
    logic [EXP_W:0]    w_e;
    assign w_up = i_g & (i_r | i_s | i_m[0]);
    assign w_zero = ~|{i_m, i_g, i_r, i_s};
    assign w_sum = {1'b0, i_m} + {{MANT_W{1'b0}}, w_up};
    assign w_m = w_sum[MANT_W] ? w_sum[MANT_W:1] : w_sum[MANT_W-1:0];
    assign w_e = i_e + {{EXP_W{1'b0}}, w_sum[MANT_W]};
    // Later assignments take priority: overflow beats zero beats subnormal.
    always_comb begin
        o_overflow = w_e >= E_TOP;
        o_result = '{sign: i_sign, exp: w_e[EXP_W-1:0], frac: w_m[MANT_W-2:0]};
        if (!w_m[MANT_W-1] && w_e <= E_ONE) o_result.exp = '0;
        if (w_zero) o_result = '0;
        if (o_overflow) o_result = '{sign: i_sign, exp: EXP_MAX, frac: '0};
    end
endmodule

// File: rtl/fp_normalizer.sv
// fp_normalizer: bit-serial leading-zero normalization followed by RNE rounding
// of one aligned ALU result per handshake.
module fp_normalizer
    import fp_pkg::*;
(
    input logic clock,
    input logic reset,
    fp_normalizer_if.slave bus
);
    state_t            r_state;
    state_t            w_next;
    logic [MANT_W-1:0] r_m;
    logic              r_g;
    logic              r_r;
    logic              r_s;
    logic              r_sign;
    logic [EXP_W:0]    r_e;
    fp32_t             r_result;
    logic              r_overflow;
    fp32_t             w_result;
    logic              w_overflow;
    logic              w_accept;
    logic              w_stop;
    assign w_accept = bus.in_valid && r_state == IDLE;
    // Shifting stops on overflow, exact zero, a set hidden bit, or the subnormal floor.
    assign w_stop = r_e >= E_TOP || ~|{r_m, r_g, r_r, r_s} || r_m[MANT_W-1] || r_e <= E_ONE;
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && w_accept) ? NORM :
                 (r_state == NORM && w_stop) ? ROUND :
                 (r_state == ROUND) ? DONE :
                 (r_state == DONE && bus.out_ready) ? IDLE : r_state;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_m <= '0;
            r_g <= 1'b0;
            r_r <= 1'b0;
            r_s <= 1'b0;
            r_sign <= 1'b0;
            r_e <= '0;
            r_result <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m <= bus.carry_out ? {1'b1, bus.aligned_result[MANT_W-1:1]} : bus.aligned_result;
                r_g <= bus.carry_out ? bus.aligned_result[0] : bus.grs[2];
                r_r <= bus.carry_out ? bus.grs[2] : bus.grs[1];
                r_s <= bus.carry_out ? |bus.grs[1:0] : bus.grs[0];
                r_e <= {1'b0, bus.exponent} + {{EXP_W{1'b0}}, bus.carry_out};
                r_sign <= bus.aligned_sign;
            end else if (r_state == NORM && !w_stop) begin
                r_m <= {r_m[MANT_W-2:0], r_g};
                r_g <= r_r;
                r_r <= 1'b0;
                r_e <= r_e - E_ONE;
            end
            if (r_state == ROUND) begin
                r_result <= w_result;
                r_overflow <= w_overflow;
            end
        end
    end
    fp_round u_round (
        .i_m(r_m),
        .i_g(r_g),
        .i_r(r_r),
        .i_s(r_s),
        .i_sign(r_sign),
        .i_e(r_e),
        .o_result(w_result),
        .o_overflow(w_overflow)
    );
    assign bus.in_ready = r_state == IDLE;
    assign bus.out_valid = r_state == DONE;
    assign bus.result = r_result;
    assign bus.overflow = r_overflow;
endmodule
